// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-back L1 data cache.
// Pure declarations: no logic, no latency.
// Imported by the interfaces, the storage array and the cache controller.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int BLOCK_W     = 128;
  localparam int WORD_W      = 32;
  localparam int MEM_ADDR_W  = 28;
  localparam int OFFSET_BITS = 4;

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side buses of the data cache.
// Wires only: no latency.
// CPU stalls on CPU_BUSYWAIT; the cache stalls on MEM_BUSYWAIT.
interface data_cache_cpu_if;
  import data_cache_pkg::*;

  logic              CPU_READ;
  logic              CPU_WRITE;
  logic [31:0]       CPU_ADDRESS;
  logic [WORD_W-1:0] CPU_WRITEDATA;
  logic [3:0]        CPU_BYTE_EN;
  logic [WORD_W-1:0] CPU_READDATA;
  logic              CPU_BUSYWAIT;

  // Pipeline MEM stage side
  modport master (
    output CPU_READ, CPU_WRITE, CPU_ADDRESS, CPU_WRITEDATA, CPU_BYTE_EN,
    input  CPU_READDATA, CPU_BUSYWAIT
  );

  // Cache side
  modport slave (
    input  CPU_READ, CPU_WRITE, CPU_ADDRESS, CPU_WRITEDATA, CPU_BYTE_EN,
    output CPU_READDATA, CPU_BUSYWAIT
  );
endinterface

interface data_cache_mem_if;
  import data_cache_pkg::*;

  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
  logic [BLOCK_W-1:0]    MEM_WRITEDATA;
  logic [BLOCK_W-1:0]    MEM_READDATA;
  logic                  MEM_BUSYWAIT;

  // Cache side (initiator)
  modport master (
    output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    input  MEM_READDATA, MEM_BUSYWAIT
  );

  // Data memory side (responder)
  modport slave (
    input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
    output MEM_READDATA, MEM_BUSYWAIT
  );
endinterface

// File: rtl/data_cache_storage.sv
// Line storage: valid/dirty/tag/data arrays with one combinational read port.
// Read is combinational; writes (byte merge, block fill, dirty clear) land at posedge.
// No backpressure; the controller decides when to write.
module data_cache_storage
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 28 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] idx,
  output logic                  valid,
  output logic                  dirty,
  output logic [TAG_BITS-1:0]   tag,
  output logic [BLOCK_W-1:0]    data,
  input  logic                  merge_en,
  input  logic [1:0]            word_sel,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [3:0]            byte_en,
  input  logic                  fill_en,
  input  logic [TAG_BITS-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0]    fill_data,
  input  logic                  clean_en
);
  localparam int NUM_LINES = 2 ** INDEX_BITS;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign data  = data_q[idx];

  // Line updates: a fill replaces the whole line clean, a merge writes lanes and marks dirty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (fill_en) begin
        data_q[idx]  <= fill_data;
        tag_q[idx]   <= fill_tag;
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (merge_en) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) begin
            data_q[idx][{word_sel, b[1:0], 3'b000} +: 8] <= wdata[8*b +: 8];
          end
        end
        dirty_q[idx] <= 1'b1;
      end
      if (clean_en) begin
        dirty_q[idx] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate L1 data cache controller.
// Hits: zero stall; misses: optional writeback + allocate, then one hit cycle.
// Stalls the CPU via CPU_BUSYWAIT; waits on MEM_BUSYWAIT once a memory phase has started.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 28 - INDEX_BITS
) (
  input logic             CLK,
  input logic             RESET,
  data_cache_cpu_if.slave cpu,
  data_cache_mem_if.master mem
);
  state_t                state;
  logic                  started;
  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [BLOCK_W-1:0]    mem_writedata;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   cpu_tag;
  logic [1:0]            word_sel;
  logic                  line_valid;
  logic                  line_dirty;
  logic [TAG_BITS-1:0]   line_tag;
  logic [BLOCK_W-1:0]    line_data;
  logic                  req;
  logic                  hit;
  logic                  done;
  logic                  unused_addr_bits;

  assign idx              = cpu.CPU_ADDRESS[OFFSET_BITS +: INDEX_BITS];
  assign cpu_tag          = cpu.CPU_ADDRESS[31 -: TAG_BITS];
  assign word_sel         = cpu.CPU_ADDRESS[3:2];
  assign unused_addr_bits = ^cpu.CPU_ADDRESS[1:0];

  assign req  = cpu.CPU_READ | cpu.CPU_WRITE;
  assign hit  = line_valid && (line_tag == cpu_tag);
  // The first cycle of a phase may still see the previous transfer's busywait.
  assign done = started && !mem.MEM_BUSYWAIT;

  assign cpu.CPU_READDATA = line_data[{word_sel, 5'b00000} +: WORD_W];
  // Held while reset is asserted so an aborted miss does not keep the pipeline stalled.
  assign cpu.CPU_BUSYWAIT = !RESET && ((req && !hit && state == IDLE) || state != IDLE);

  assign mem.MEM_READ      = mem_read;
  assign mem.MEM_WRITE     = mem_write;
  assign mem.MEM_ADDRESS   = mem_address;
  assign mem.MEM_WRITEDATA = mem_writedata;

  data_cache_storage #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_storage (
    .clk       (CLK),
    .rst       (RESET),
    .idx       (idx),
    .valid     (line_valid),
    .dirty     (line_dirty),
    .tag       (line_tag),
    .data      (line_data),
    .merge_en  (state == IDLE && cpu.CPU_WRITE && hit),
    .word_sel  (word_sel),
    .wdata     (cpu.CPU_WRITEDATA),
    .byte_en   (cpu.CPU_BYTE_EN),
    .fill_en   (state == ALLOCATE && done),
    .fill_tag  (cpu_tag),
    .fill_data (mem.MEM_READDATA),
    .clean_en  (state == WRITEBACK && done)
  );

  // Miss sequencing with registered memory request outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      started       <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            started <= 1'b0;
            if (line_valid && line_dirty) begin
              state         <= WRITEBACK;
              mem_write     <= 1'b1;
              mem_address   <= {line_tag, idx};
              mem_writedata <= line_data;
            end else begin
              state       <= ALLOCATE;
              mem_read    <= 1'b1;
              mem_address <= {cpu_tag, idx};
            end
          end
        end
        WRITEBACK: begin
          if (done) begin
            state       <= ALLOCATE;
            started     <= 1'b0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
            mem_address <= {cpu_tag, idx};
          end else begin
            started <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (done) begin
            state    <= IDLE;
            started  <= 1'b0;
            mem_read <= 1'b0;
          end else begin
            started <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          started   <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: table of accesses plus a reset-during-miss sequence.
// A behavioural block memory with programmable latency responds on the memory bus.
// Read data is checked through a scoreboard queue against a reference word memory.
module tb_data_cache;
  import data_cache_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  data_cache_cpu_if cpu ();
  data_cache_mem_if mem ();

  data_cache #(.INDEX_BITS(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .cpu   (cpu),
    .mem   (mem)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural block memory ----------------
  int lat = 0;
  int cnt;
  logic [127:0] bmem [logic [27:0]];
  logic [29:0]  last_req;
  logic [29:0]  cur_req;
  logic [127:0] rdata;

  function automatic logic [31:0] pat(input logic [27:0] a, input logic [1:0] w);
    return {a, w, 2'b11};
  endfunction

  function automatic logic [127:0] mem_blk(input logic [27:0] a);
    logic [127:0] b;
    if (bmem.exists(a)) return bmem[a];
    for (int w = 0; w < 4; w++) b[32*w +: 32] = pat(a, w[1:0]);
    return b;
  endfunction

  assign cur_req          = {mem.MEM_READ, mem.MEM_WRITE, mem.MEM_ADDRESS};
  assign mem.MEM_BUSYWAIT = (mem.MEM_READ | mem.MEM_WRITE) && !(cur_req == last_req && cnt >= lat);
  assign mem.MEM_READDATA = rdata;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_req <= '0;
      cnt      <= 0;
    end else begin
      if (cur_req != last_req) cnt <= 0;
      else if (cnt < lat)      cnt <= cnt + 1;
      last_req <= cur_req;
    end
  end

  always @(posedge CLK) begin
    if (!RESET && mem.MEM_WRITE && !mem.MEM_BUSYWAIT) bmem[mem.MEM_ADDRESS] = mem.MEM_WRITEDATA;
  end

  always @(negedge CLK) rdata = mem_blk(mem.MEM_ADDRESS);

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] refm [logic [29:0]];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [127:0] b;
    if (refm.exists(a[31:2])) return refm[a[31:2]];
    b = mem_blk(a[31:4]);
    return b[32*a[3:2] +: 32];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  task automatic run_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, output int stall, output int nwb, output int nrd,
                            output int bad, output logic [27:0] wba, output logic [27:0] rda,
                            output logic [127:0] wbd);
    logic [31:0] exp;
    stall = 0; nwb = 0; nrd = 0; bad = 0; wba = '0; rda = '0; wbd = '0;
    @(negedge CLK);
    cpu.CPU_READ = rd; cpu.CPU_WRITE = wr; cpu.CPU_ADDRESS = a;
    cpu.CPU_WRITEDATA = wd; cpu.CPU_BYTE_EN = be;
    if (rd && !wr) exp_q.push_back(ref_word(a));
    forever begin
      #1;
      if (mem.MEM_READ && mem.MEM_WRITE) bad++;
      if (mem.MEM_WRITE && nrd > 0) bad++;
      if (mem.MEM_WRITE) begin
        if (nwb == 0) begin wba = mem.MEM_ADDRESS; wbd = mem.MEM_WRITEDATA; end
        nwb++;
      end
      if (mem.MEM_READ) begin
        if (nrd == 0) rda = mem.MEM_ADDRESS;
        nrd++;
      end
      if (!cpu.CPU_BUSYWAIT) break;
      if (stall >= 200) begin
        chk("busywait_timeout", 128'(cpu.CPU_BUSYWAIT), 128'(0));
        break;
      end
      @(negedge CLK);
      stall++;
    end
    if (rd && !wr) begin
      exp = exp_q.pop_front();
      chk($sformatf("read_data@%0h", a), 128'(cpu.CPU_READDATA), 128'(exp));
    end
    @(posedge CLK);
    #1;
    cpu.CPU_READ = 1'b0; cpu.CPU_WRITE = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          exp_wb;
    bit          exp_al;
    logic [27:0] wb_addr;
    logic [27:0] al_addr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         v;
    int           stall, nwb, nrd, bad, exp_stall;
    logic [27:0]  wba, rda;
    logic [127:0] wbd, exp_wbd;
    logic [31:0]  old;
    bit           seen;

    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'h0, 1'b0, 1'b1, 28'h0,  28'h1};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0014, 32'hDEADBEEF,   4'hF, 1'b0, 1'b0, 28'h0,  28'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,          4'h0, 1'b0, 1'b0, 28'h0,  28'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h0000_00AA,  4'h1, 1'b0, 1'b0, 28'h0,  28'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,          4'h0, 1'b0, 1'b0, 28'h0,  28'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0090, 32'h0,          4'h0, 1'b1, 1'b1, 28'h1,  28'h9};
    tbl[6]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,          4'h0, 1'b0, 1'b1, 28'h0,  28'h1};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h12345678,   4'hF, 1'b0, 1'b1, 28'h0,  28'h20};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,          4'h0, 1'b0, 1'b0, 28'h0,  28'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_1200, 32'h0,          4'h0, 1'b1, 1'b1, 28'h20, 28'h120};
    tbl[10] = '{1'b1, 1'b1, 32'h0000_0204, 32'hCAFEF00D,   4'h6, 1'b0, 1'b1, 28'h0,  28'h20};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,          4'h0, 1'b0, 1'b0, 28'h0,  28'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,          4'h0, 1'b0, 1'b0, 28'h0,  28'h0};
    tbl[13] = '{1'b1, 1'b0, 32'h0000_0028, 32'h0,          4'h0, 1'b0, 1'b1, 28'h0,  28'h2};

    cpu.CPU_READ = 1'b0; cpu.CPU_WRITE = 1'b0; cpu.CPU_ADDRESS = '0;
    cpu.CPU_WRITEDATA = '0; cpu.CPU_BYTE_EN = '0;
    RESET = 1'b1;
    #12;
    chk("rst_mem_read",      128'(mem.MEM_READ),      128'(0));
    chk("rst_mem_write",     128'(mem.MEM_WRITE),     128'(0));
    chk("rst_mem_address",   128'(mem.MEM_ADDRESS),   128'(0));
    chk("rst_mem_writedata", mem.MEM_WRITEDATA,       128'(0));
    chk("rst_cpu_busywait",  128'(cpu.CPU_BUSYWAIT),  128'(0));
    chk("rst_cpu_readdata",  128'(cpu.CPU_READDATA),  128'(0));
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 14; i++) begin
      v   = tbl[i];
      lat = i % 3;
      for (int w = 0; w < 4; w++) exp_wbd[32*w +: 32] = ref_word({v.wb_addr, w[1:0], 2'b00});
      old = ref_word(v.addr);
      run_access(v.rd, v.wr, v.addr, v.wd, v.be, stall, nwb, nrd, bad, wba, rda, wbd);
      exp_stall = v.exp_al ? (v.exp_wb ? 5 + 2*lat : 3 + lat) : 0;
      chk($sformatf("r%0d_stall", i),      128'(stall),   128'(exp_stall));
      chk($sformatf("r%0d_wb_seen", i),    128'(nwb > 0), 128'(v.exp_wb));
      chk($sformatf("r%0d_alloc_seen", i), 128'(nrd > 0), 128'(v.exp_al));
      chk($sformatf("r%0d_bus_order", i),  128'(bad),     128'(0));
      if (v.exp_wb) begin
        chk($sformatf("r%0d_wb_addr", i), 128'(wba), 128'(v.wb_addr));
        chk($sformatf("r%0d_wb_data", i), wbd,       exp_wbd);
      end
      if (v.exp_al) chk($sformatf("r%0d_alloc_addr", i), 128'(rda), 128'(v.al_addr));
      if (v.wr) refm[v.addr[31:2]] = merge(old, v.wd, v.be);
    end

    // Reset while a fetch is outstanding: requests must drop at once
    lat = 3;
    @(negedge CLK);
    cpu.CPU_READ = 1'b1; cpu.CPU_WRITE = 1'b0; cpu.CPU_ADDRESS = 32'h0000_0030;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      #1;
      if (mem.MEM_READ) begin seen = 1'b1; break; end
    end
    chk("rstmid_alloc_reached", 128'(seen), 128'(1));
    RESET = 1'b1;
    #1;
    chk("rstmid_mem_read",     128'(mem.MEM_READ),     128'(0));
    chk("rstmid_mem_write",    128'(mem.MEM_WRITE),    128'(0));
    chk("rstmid_cpu_busywait", 128'(cpu.CPU_BUSYWAIT), 128'(0));
    chk("rstmid_cpu_readdata", 128'(cpu.CPU_READDATA), 128'(0));
    cpu.CPU_READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    // Dirty lines were discarded by reset: expectations now come from memory.
    refm.delete();

    run_access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'h0, stall, nwb, nrd, bad, wba, rda, wbd);
    chk("post_rst_miss_again", 128'(nrd > 0), 128'(1));
    chk("post_rst_alloc_addr", 128'(rda),     128'(28'h3));
    chk("post_rst_no_wb",      128'(nwb),     128'(0));
    run_access(1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h0, stall, nwb, nrd, bad, wba, rda, wbd);
    chk("post_rst_lost_merge_miss", 128'(nrd > 0), 128'(1));
    run_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, stall, nwb, nrd, bad, wba, rda, wbd);
    chk("post_rst_same_line_hit", 128'(stall), 128'(0));

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
